maxpool_seq_ctrl: RTL and testbench

MAXPOOL_SEQ_CTRL -- requirements
Module: maxpool_seq_ctrl

---
 rtl/maxpool_seq_ctrl.sv | 133 +++++++++++++
 tb/tb_maxpool_seq_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/maxpool_seq_ctrl.sv
// maxpool_seq_ctrl: sequences one 7x7 max-pooling pass over NUM_WIN windows.
// In each window cycle it captures the pooled value, then writes it into the
// result vector one edge later.
// Optional feature: define MAXPOOL_RELU_EN to clamp negative pooled values
// (two's complement) to zero before they are stored.
module maxpool_seq_ctrl #(
    parameter int IntSize = 8,
    parameter int NUM_WIN = 49
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic                         hold,
    input  logic [IntSize-1:0]           pool_in,
    output logic [20:0]                  maxPoolState,
    output logic                         busy,
    output logic                         done,
    output logic                         result_valid,
    output logic [IntSize*NUM_WIN-1:0]   n_pic2
);

    localparam int IdxW = (NUM_WIN > 1) ? $clog2(NUM_WIN) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_WIN - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t               state_r;
    logic [IdxW-1:0]      idx_r;
    logic                 wr_en_r;
    logic [IdxW-1:0]      wr_idx_r;
    logic [IntSize-1:0]   wr_data_r;

    // Value conditioning applied to each captured pooled element.
    function automatic logic [IntSize-1:0] cond_value(input logic [IntSize-1:0] v);
        logic [IntSize-1:0] r;
`ifdef MAXPOOL_RELU_EN
        if (v[IntSize-1]) begin
            r = '0;
        end else begin
            r = v;
        end
`else
        r = v;
`endif
        return r;
    endfunction

    // Control FSM: window index, capture register and all status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            idx_r        <= '0;
            wr_en_r      <= 1'b0;
            wr_idx_r     <= '0;
            wr_data_r    <= '0;
            maxPoolState <= 21'd0;
            busy         <= 1'b0;
            done         <= 1'b0;
            result_valid <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    wr_en_r      <= 1'b0;
                    done         <= 1'b0;
                    maxPoolState <= 21'd0;
                    if (start) begin
                        state_r      <= ST_RUN;
                        idx_r        <= '0;
                        result_valid <= 1'b0;
                        busy         <= 1'b1;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (!hold) begin
                        wr_en_r   <= 1'b1;
                        wr_idx_r  <= idx_r;
                        wr_data_r <= cond_value(pool_in);
                        if (idx_r == LastIdx) begin
                            // Last window captured; its write lands during DRAIN.
                            state_r      <= ST_DRAIN;
                            idx_r        <= '0;
                            maxPoolState <= 21'd0;
                        end else begin
                            idx_r        <= idx_r + IdxW'(1);
                            maxPoolState <= 21'(idx_r + IdxW'(1));
                        end
                    end else begin
                        wr_en_r <= 1'b0;
                    end
                end
                ST_DRAIN: begin
                    wr_en_r      <= 1'b0;
                    state_r      <= ST_DONE;
                    busy         <= 1'b0;
                    done         <= 1'b1;
                    result_valid <= 1'b1;
                end
                ST_DONE: begin
                    wr_en_r <= 1'b0;
                    done    <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r      <= ST_IDLE;
                    idx_r        <= '0;
                    wr_en_r      <= 1'b0;
                    maxPoolState <= 21'd0;
                    busy         <= 1'b0;
                    done         <= 1'b0;
                end
            endcase
        end
    end

    // Result storage: one element written per capture, one edge after capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_pic2 <= '0;
        end else if (wr_en_r) begin
            n_pic2[int'(wr_idx_r) * IntSize +: IntSize] <= wr_data_r;
        end else begin
            n_pic2 <= n_pic2;
        end
    end

endmodule

// File: tb/tb_maxpool_seq_ctrl.sv
// Scoreboard bench for maxpool_seq_ctrl: stimulus pushes expected probes and
// pass results; a negedge monitor pops and compares them.
module tb_maxpool_seq_ctrl;

    localparam int IntSize = 8;
    localparam int NUM_WIN = 49;
    localparam int W = IntSize * NUM_WIN;

    logic               clk = 1'b0;
    logic               rst_n = 1'b1;
    logic               start = 1'b0;
    logic               hold = 1'b0;
    logic [IntSize-1:0] pool_in;
    logic [20:0]        maxPoolState;
    logic               busy;
    logic               done;
    logic               result_valid;
    logic [W-1:0]       n_pic2;

    int n_vec = 0;
    int n_miss = 0;
    int cyc = 0;
    int pool_mode = 0;

    // sig: 0 maxPoolState, 1 result_valid, 2 busy, 3 done
    typedef struct {
        int          cyc;
        int          sig;
        logic [31:0] val;
    } probe_t;

    typedef struct {
        int           cyc;
        logic [W-1:0] data;
    } pass_t;

    probe_t       pq[$];
    pass_t        dq[$];
    logic [W-1:0] exp_mem = '0;

    maxpool_seq_ctrl #(.IntSize(IntSize), .NUM_WIN(NUM_WIN)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .hold(hold), .pool_in(pool_in),
        .maxPoolState(maxPoolState), .busy(busy), .done(done),
        .result_valid(result_valid), .n_pic2(n_pic2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Datapath model: value presented for window k under each stimulus mode.
    function automatic logic [7:0] pool_raw(input int mode, input int k);
        logic [7:0] r;
        case (mode)
            0:       r = 8'(k + 1);
            1:       r = 8'hF0;
            default: r = 8'(8'h40 + k);
        endcase
        return r;
    endfunction

    function automatic logic [7:0] exp_val(input int mode, input int k);
        logic [7:0] r;
        r = pool_raw(mode, k);
`ifdef MAXPOOL_RELU_EN
        if (r[7]) r = 8'h00;
`endif
        return r;
    endfunction

    assign pool_in = pool_raw(pool_mode, int'(maxPoolState[5:0]));

    task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, got, exp);
        end
    endtask

    task automatic push_probe(input int c, input int sig, input int val);
        probe_t p;
        p.cyc = c;
        p.sig = sig;
        p.val = 32'(val);
        pq.push_back(p);
    endtask

    // Monitor: compare scheduled probes and every done pulse against the scoreboard.
    always @(negedge clk) begin
        probe_t p;
        pass_t  d;
        while (pq.size() > 0 && pq[0].cyc <= cyc) begin
            p = pq.pop_front();
            if (p.cyc < cyc) begin
                chk("probe_missed", W'(p.cyc), W'(cyc));
            end else begin
                case (p.sig)
                    0:       chk("maxPoolState", W'(maxPoolState), W'(p.val));
                    1:       chk("result_valid", W'(result_valid), W'(p.val));
                    2:       chk("busy", W'(busy), W'(p.val));
                    default: chk("done", W'(done), W'(p.val));
                endcase
            end
        end
        if (done === 1'b1) begin
            if (dq.size() == 0) begin
                chk("unexpected_done", W'(1), W'(0));
            end else begin
                d = dq.pop_front();
                chk("done_cycle", W'(cyc), W'(d.cyc));
                chk("n_pic2", n_pic2, d.data);
                chk("result_valid_at_done", W'(result_valid), W'(1));
            end
        end
    end

    // One pass: start is raised at the current negedge, accepted on the next edge.
    task automatic run_pass(input int mode, input int hold_at, input int glitch_at, input int abort_at);
        int a;
        int h;
        int n;
        int t;
        pass_t d;
        h = (hold_at >= 0) ? 3 : 0;
        a = cyc + 1;
        pool_mode = mode;
        start = 1'b1;
        push_probe(a, 1, 0);
        push_probe(a, 2, 1);
        for (int k = 0; k < NUM_WIN; k++) begin
            t = a + k + ((hold_at >= 0 && k > hold_at) ? 3 : 0);
            if (abort_at < 0 || k < abort_at) begin
                push_probe(t, 0, k);
                if (k == hold_at) begin
                    for (int j = 1; j <= 3; j++) push_probe(t + j, 0, k);
                end
            end
        end
        if (abort_at < 0) begin
            push_probe(a + 49 + h, 0, 0);
            push_probe(a + 49 + h, 2, 1);
            push_probe(a + 50 + h, 2, 0);
            push_probe(a + 50 + h, 3, 1);
            push_probe(a + 51 + h, 3, 0);
            push_probe(a + 51 + h, 1, 1);
            d.cyc = a + 50 + h;
            for (int k = 0; k < NUM_WIN; k++) d.data[k*IntSize +: IntSize] = exp_val(mode, k);
            dq.push_back(d);
        end
        forever begin
            @(negedge clk);
            n = cyc - a;
            if (n == 0) start = 1'b0;
            if (n == glitch_at) start = 1'b1;
            if (n == glitch_at + 1) start = 1'b0;
            if (n == hold_at) hold = 1'b1;
            if (n == hold_at + 3) hold = 1'b0;
            if (n == abort_at) begin
                #2 rst_n = 1'b0;
                #1;
                chk("rst_busy", W'(busy), W'(0));
                chk("rst_maxPoolState", W'(maxPoolState), W'(0));
                chk("rst_n_pic2", n_pic2, W'(0));
                chk("rst_result_valid", W'(result_valid), W'(0));
                @(negedge clk);
                rst_n = 1'b1;
                hold = 1'b0;
                start = 1'b0;
                exp_mem = '0;
                return;
            end
            if (n >= 51 + h) break;
        end
        exp_mem = d.data;
    endtask

    initial begin
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_busy", W'(busy), W'(0));
        chk("reset_done", W'(done), W'(0));
        chk("reset_result_valid", W'(result_valid), W'(0));
        chk("reset_maxPoolState", W'(maxPoolState), W'(0));
        chk("reset_n_pic2", n_pic2, W'(0));
        rst_n = 1'b1;
        run_pass(0, -1, -1, -1);   // plain pass, element k = k+1
        run_pass(2, 10, -1, -1);   // hold 3 cycles at window 10
        run_pass(0, -1, 20, -1);   // start pulse mid-pass is ignored
        run_pass(0, -1, -1, 30);   // reset mid-pass
        run_pass(0, -1, -1, -1);   // normal pass right after reset release
        run_pass(1, -1, -1, -1);   // negative input, ReLU dependent
        run_pass(0, -1, -1, -1);   // back-to-back pair
        run_pass(2, -1, -1, -1);
        repeat (4) @(negedge clk);
        chk("probes_left", W'(pq.size()), W'(0));
        chk("dones_left", W'(dq.size()), W'(0));
        chk("final_n_pic2", n_pic2, exp_mem);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
